// File: rtl/mips_run_monitor.sv
// Run controller: counts cycles/retirements and ends a run on HALT, PC stall or cycle limit.
// Optional PC history buffer enabled by defining MIPS_RUN_MON_HIST_EN.
module mips_run_monitor #(
   parameter int          AW          = 32,
   parameter int          CW          = 16,
   parameter int          MAX_CYCLES  = 1024,
   parameter logic [31:0] HALT_INSTR  = 32'h0000000C,
   parameter int          STALL_LIMIT = 4
`ifdef MIPS_RUN_MON_HIST_EN
   ,
   parameter int          HIST_DEPTH  = 8
`endif
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          instr_valid,
   input  logic [AW-1:0] pc,
   input  logic [31:0]   instr,
   output logic          running,
   output logic          done,
   output logic          halted,
   output logic          timeout,
   output logic [CW-1:0] cycle_count,
   output logic [CW-1:0] instr_count
`ifdef MIPS_RUN_MON_HIST_EN
   ,
   input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
   output logic [AW-1:0]                 hist_pc
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [CW-1:0] stall_cnt;
   logic [AW-1:0] last_pc;
   logic          have_last;

   logic          in_run;
   logic          launch;
   logic [CW-1:0] cyc_nxt;
   logic          is_halt;
   logic          same_pc;
   logic          stall_hit;
   logic          to_hit;
   logic          halt_ev;
   logic          end_ev;

   assign in_run  = (state_q == RUN);
   assign launch  = !in_run && start;
   assign cyc_nxt = cycle_count + CW'(1);
   assign is_halt = instr_valid && (instr == HALT_INSTR);
   assign same_pc = instr_valid && have_last && (pc == last_pc);

   // Stall limit of zero disables stall detection entirely
   assign stall_hit = (STALL_LIMIT != 0) && same_pc &&
                      ((stall_cnt + CW'(1)) == CW'(STALL_LIMIT));
   assign to_hit    = (cyc_nxt == CW'(MAX_CYCLES));
   assign halt_ev   = is_halt || stall_hit;
   assign end_ev    = halt_ev || to_hit;
   assign running   = in_run;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (end_ev) state_d = DONE;
         DONE:    if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done        <= 1'b0;
         halted      <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= '0;
         instr_count <= '0;
         stall_cnt   <= '0;
         last_pc     <= '0;
         have_last   <= 1'b0;
      end else if (launch) begin
         done        <= 1'b0;
         halted      <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= '0;
         instr_count <= '0;
         stall_cnt   <= '0;
         last_pc     <= '0;
         have_last   <= 1'b0;
      end else if (in_run) begin
         cycle_count <= cyc_nxt;
         if (instr_valid) begin
            instr_count <= instr_count + CW'(1);
            last_pc     <= pc;
            have_last   <= 1'b1;
            stall_cnt   <= same_pc ? stall_cnt + CW'(1) : '0;
         end
         // Halt wins over a coincident timeout
         if (end_ev) begin
            done    <= 1'b1;
            halted  <= halt_ev;
            timeout <= !halt_ev;
         end
      end
   end

`ifdef MIPS_RUN_MON_HIST_EN
   localparam int HW = $clog2(HIST_DEPTH);

   logic [AW-1:0] hist [HIST_DEPTH];
   logic [HW-1:0] wptr;
   logic [HW-1:0] rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst || launch) begin
         for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
         wptr <= '0;
      end else if (in_run && instr_valid) begin
         hist[wptr] <= pc;
         wptr       <= wptr + HW'(1);
      end
   end

   // Newest entry sits just behind the write pointer
   assign rd_ptr  = wptr - HW'(1) - hist_idx;
   assign hist_pc = hist[rd_ptr];
`endif

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed self-checking bench for mips_run_monitor.
// A second instance with MAX_CYCLES=8 covers the coincident halt/timeout case.
module tb_mips_run_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] instr;

   logic        running, done, halted, timeout;
   logic [15:0] cycle_count, instr_count;
   logic        running8, done8, halted8, timeout8;
   logic [15:0] cycle_count8, instr_count8;

`ifdef MIPS_RUN_MON_HIST_EN
   logic [2:0]  hist_idx;
   logic [31:0] hist_pc, hist_pc8;
`endif

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mips_run_monitor #(
      .AW(32), .CW(16), .MAX_CYCLES(1024),
      .HALT_INSTR(32'h0000000C), .STALL_LIMIT(4)
`ifdef MIPS_RUN_MON_HIST_EN
      , .HIST_DEPTH(8)
`endif
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .instr_valid(instr_valid), .pc(pc), .instr(instr),
      .running(running), .done(done), .halted(halted),
      .timeout(timeout), .cycle_count(cycle_count),
      .instr_count(instr_count)
`ifdef MIPS_RUN_MON_HIST_EN
      , .hist_idx(hist_idx), .hist_pc(hist_pc)
`endif
   );

   mips_run_monitor #(
      .AW(32), .CW(16), .MAX_CYCLES(8),
      .HALT_INSTR(32'h0000000C), .STALL_LIMIT(4)
`ifdef MIPS_RUN_MON_HIST_EN
      , .HIST_DEPTH(8)
`endif
   ) dut8 (
      .clk(clk), .rst(rst), .start(start),
      .instr_valid(instr_valid), .pc(pc), .instr(instr),
      .running(running8), .done(done8), .halted(halted8),
      .timeout(timeout8), .cycle_count(cycle_count8),
      .instr_count(instr_count8)
`ifdef MIPS_RUN_MON_HIST_EN
      , .hist_idx(hist_idx), .hist_pc(hist_pc8)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] p,
                        input logic [31:0] i);
      instr_valid = v;
      pc          = p;
      instr       = i;
      tick();
   endtask

   task automatic pulse_start;
      start       = 1'b1;
      instr_valid = 1'b0;
      tick();
      start = 1'b0;
   endtask

   logic [31:0] stall_pcs [7];

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      instr_valid = 1'b0;
      pc          = '0;
      instr       = '0;
`ifdef MIPS_RUN_MON_HIST_EN
      hist_idx    = '0;
`endif
      tick();
      tick();
      chk("rst_running", {31'd0, running}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_cycle", {16'd0, cycle_count}, 0);
`ifdef MIPS_RUN_MON_HIST_EN
      chk("rst_hist", hist_pc, 0);
`endif
      rst = 1'b0;
      tick();
      chk("idle_running", {31'd0, running}, 0);

      // Timeout after 1024 cycles with a retirement every cycle
      pulse_start();
      chk("to_running", {31'd0, running}, 1);
      chk("to_cycle0", {16'd0, cycle_count}, 0);
      for (int c = 0; c < 1023; c++) drive(1'b1, 32'h1000 + 4 * c, 0);
      chk("to_pre_running", {31'd0, running}, 1);
      chk("to_pre_cycle", {16'd0, cycle_count}, 1023);
      drive(1'b1, 32'h3000, 0);
      chk("to_done", {31'd0, done}, 1);
      chk("to_timeout", {31'd0, timeout}, 1);
      chk("to_halted", {31'd0, halted}, 0);
      chk("to_running_end", {31'd0, running}, 0);
      chk("to_cycle", {16'd0, cycle_count}, 1024);
      chk("to_instr", {16'd0, instr_count}, 1024);

      // Halt instruction as 10th retirement in cycle 15
      pulse_start();
      chk("h_cleared_done", {31'd0, done}, 0);
      chk("h_cleared_timeout", {31'd0, timeout}, 0);
      for (int c = 1; c <= 5; c++) drive(1'b0, 32'h0, 0);
      for (int c = 6; c <= 14; c++) drive(1'b1, 32'h2000 + 4 * c, 0);
      chk("h_pre_running", {31'd0, running}, 1);
      chk("h_pre_instr", {16'd0, instr_count}, 9);
      drive(1'b1, 32'h2100, 32'h0000000C);
      chk("h_done", {31'd0, done}, 1);
      chk("h_halted", {31'd0, halted}, 1);
      chk("h_timeout", {31'd0, timeout}, 0);
      chk("h_instr", {16'd0, instr_count}, 10);
      chk("h_cycle", {16'd0, cycle_count}, 15);
      drive(1'b1, 32'h2200, 0);
      drive(1'b1, 32'h2204, 0);
      chk("h_hold_cycle", {16'd0, cycle_count}, 15);
      chk("h_hold_instr", {16'd0, instr_count}, 10);
      chk("h_hold_done", {31'd0, done}, 1);

      // PC stall reaching the limit on the 7th retirement
      stall_pcs = '{32'h40, 32'h44, 32'h48, 32'h48, 32'h48, 32'h48, 32'h48};
      pulse_start();
      for (int k = 0; k < 6; k++) drive(1'b1, stall_pcs[k], 0);
      chk("s_pre_running", {31'd0, running}, 1);
      drive(1'b1, stall_pcs[6], 0);
      chk("s_done", {31'd0, done}, 1);
      chk("s_halted", {31'd0, halted}, 1);
      chk("s_timeout", {31'd0, timeout}, 0);
      chk("s_instr", {16'd0, instr_count}, 7);

      // Only three repeats of 0x48: run continues
      stall_pcs = '{32'h40, 32'h44, 32'h48, 32'h48, 32'h48, 32'h48, 32'h50};
      pulse_start();
      for (int k = 0; k < 7; k++) drive(1'b1, stall_pcs[k], 0);
      chk("ns_running", {31'd0, running}, 1);
      chk("ns_halted", {31'd0, halted}, 0);
      chk("ns_done", {31'd0, done}, 0);

      // start while in RUN is ignored
      start = 1'b1;
      drive(1'b1, 32'h54, 0);
      start = 1'b0;
      chk("ign_start_cycle", {16'd0, cycle_count}, 8);
      chk("ign_start_running", {31'd0, running}, 1);
      for (int c = 9; c <= 37; c++) drive(1'b1, 32'h100 + 4 * c, 0);
      chk("mid_cycle37", {16'd0, cycle_count}, 37);
      chk("mid_instr37", {16'd0, instr_count}, 37);

      // Asynchronous reset mid-run
      instr_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst_running", {31'd0, running}, 0);
      chk("arst_done", {31'd0, done}, 0);
      chk("arst_halted", {31'd0, halted}, 0);
      chk("arst_timeout", {31'd0, timeout}, 0);
      chk("arst_cycle", {16'd0, cycle_count}, 0);
      chk("arst_instr", {16'd0, instr_count}, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("arst_idle", {31'd0, running}, 0);
      chk("arst_idle_done", {31'd0, done}, 0);
      pulse_start();
      chk("rerun_running", {31'd0, running}, 1);
      drive(1'b1, 32'h500, 32'h0000000C);
      chk("rerun_halted", {31'd0, halted}, 1);
      chk("rerun_cycle", {16'd0, cycle_count}, 1);
      chk("rerun_instr", {16'd0, instr_count}, 1);

      // Halt coincides with the 8-cycle limit on the small instance
      pulse_start();
      for (int c = 1; c <= 7; c++) drive(1'b0, 32'h0, 0);
      chk("sim_pre_running", {31'd0, running8}, 1);
      drive(1'b1, 32'h600, 32'h0000000C);
      chk("sim_done", {31'd0, done8}, 1);
      chk("sim_halted", {31'd0, halted8}, 1);
      chk("sim_timeout", {31'd0, timeout8}, 0);
      chk("sim_cycle", {16'd0, cycle_count8}, 8);
      chk("sim_instr", {16'd0, instr_count8}, 1);
      pulse_start();
      chk("restart_running", {31'd0, running8}, 1);
      chk("restart_done", {31'd0, done8}, 0);
      chk("restart_halted", {31'd0, halted8}, 0);
      chk("restart_cycle", {16'd0, cycle_count8}, 0);
      chk("restart_instr", {16'd0, instr_count8}, 0);
      drive(1'b1, 32'h700, 32'h0000000C);
      chk("end_main", {31'd0, done}, 1);

`ifdef MIPS_RUN_MON_HIST_EN
      pulse_start();
      for (int k = 0; k < 9; k++) drive(1'b1, 4 * k, 0);
      drive(1'b1, 32'h24, 32'h0000000C);
      chk("hist_done", {31'd0, done}, 1);
      hist_idx = 3'd0;
      #1;
      chk("hist_idx0", hist_pc, 32'h24);
      hist_idx = 3'd7;
      #1;
      chk("hist_idx7", hist_pc, 32'h08);
      hist_idx = 3'd3;
      #1;
      chk("hist_idx3", hist_pc, 32'h18);
      pulse_start();
      chk("hist_cleared", hist_pc, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end

endmodule
